// File: rtl/fir_filter_ntap.sv
// N-tap direct-form FIR: shadow/active coefficient banks, pipelined adder tree,
// scaled saturating output. Define FIR_ROUND_EN for round-half-up instead of truncation.
module fir_filter_ntap #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned NTAPS       = 8,
  parameter int unsigned SHIFT       = COEFF_WIDTH - 1,
  localparam int unsigned AW         = $clog2(NTAPS),
  localparam int unsigned ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + $clog2(NTAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  x,
  input  logic                   coeff_wr,
  input  logic [AW-1:0]          coeff_addr,
  input  logic [COEFF_WIDTH-1:0] coeff_data,
  input  logic                   coeff_commit,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  y,
  output logic                   sat
);

  localparam int unsigned LEVELS = AW;

  logic signed [DATA_WIDTH-1:0]  r_dly    [1:NTAPS-1];
  logic signed [COEFF_WIDTH-1:0] r_shadow [NTAPS];
  logic signed [COEFF_WIDTH-1:0] r_active [NTAPS];
  logic signed [ACC_WIDTH-1:0]   r_tree   [LEVELS+1][NTAPS];
  logic [LEVELS:0]               r_vld;
  logic [DATA_WIDTH-1:0]         r_y;
  logic                          r_sat;
  logic                          r_out_valid;
  logic signed [DATA_WIDTH-1:0]  w_tap    [NTAPS];

  always_comb begin
    w_tap[0] = $signed(x);
    for (int k = 1; k < NTAPS; k++) begin
      w_tap[k] = r_dly[k];
    end
  end

  // Commit reads the shadow bank before any same-cycle write lands in it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < NTAPS; k++) r_dly[k] <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (in_valid) begin
        r_dly[1] <= $signed(x);
        for (int k = 2; k < NTAPS; k++) r_dly[k] <= r_dly[k-1];
      end
      if (coeff_commit) begin
        for (int k = 0; k < NTAPS; k++) r_active[k] <= r_shadow[k];
      end
      if (coeff_wr && (32'(coeff_addr) < NTAPS)) begin
        r_shadow[coeff_addr] <= $signed(coeff_data);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) r_tree[0][k] <= '0;
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        r_tree[0][k] <= ACC_WIDTH'(w_tap[k]) * ACC_WIDTH'(r_active[k]);
      end
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned NPrev = (NTAPS + (2 ** (l - 1)) - 1) / (2 ** (l - 1));
    localparam int unsigned NCur  = (NPrev + 1) / 2;
    for (genvar i = 0; i < NTAPS; i++) begin : g_node
      if ((i < NCur) && (2 * i + 1 < NPrev)) begin : g_add
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_tree[l][i] <= '0;
          else     r_tree[l][i] <= r_tree[l-1][2*i] + r_tree[l-1][2*i+1];
        end
      end else if (i < NCur) begin : g_pass
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_tree[l][i] <= '0;
          else     r_tree[l][i] <= r_tree[l-1][2*i];
        end
      end else begin : g_unused
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_tree[l][i] <= '0;
          else     r_tree[l][i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vld <= '0;
    else     r_vld <= {r_vld[LEVELS-1:0], in_valid};
  end

`ifdef FIR_ROUND_EN
  localparam int unsigned SW = ACC_WIDTH + 1;
  logic signed [SW-1:0] w_sum;
  assign w_sum = {r_tree[LEVELS][0][ACC_WIDTH-1], r_tree[LEVELS][0]}
                 + (SW'(1) << (SHIFT - 1));
`else
  localparam int unsigned SW = ACC_WIDTH;
  logic signed [SW-1:0] w_sum;
  assign w_sum = r_tree[LEVELS][0];
`endif

  logic signed [SW-1:0]      w_s;
  logic                      w_fit;
  logic [DATA_WIDTH-1:0]     w_y;

  // Value fits the output width when all bits above the output sign bit match it.
  always_comb begin
    w_s   = w_sum >>> SHIFT;
    w_fit = (&w_s[SW-1:DATA_WIDTH-1]) | ~(|w_s[SW-1:DATA_WIDTH-1]);
    w_y   = w_s[DATA_WIDTH-1:0];
    if (!w_fit) begin
      w_y = w_s[SW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y         <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_vld[LEVELS];
      if (r_vld[LEVELS]) begin
        r_y   <= w_y;
        r_sat <= ~w_fit;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign sat       = r_sat;

endmodule
